// File: rtl/i2s_axis_rx_pkg.sv
// Shared types and defaults for the I2S-to-AXI-Stream receiver.
package i2s_axis_rx_pkg;

    typedef enum logic [1:0] {
        SYNC_WAIT,
        SHIFT,
        HOLD
    } i2s_state_e;

    localparam logic I2S_CH_LEFT  = 1'b0;
    localparam logic I2S_CH_RIGHT = 1'b1;

    localparam int unsigned I2S_DATA_WIDTH    = 24;
    localparam int unsigned I2S_FIFO_DEPTH    = 4;
    localparam int unsigned I2S_SYNC_STAGES   = 2;
    localparam int unsigned I2S_ERR_CNT_WIDTH = 8;

endpackage

// File: rtl/i2s_axis_rx_if.sv
// AXI-Stream sample bus: data, valid, ready and last (last marks the right channel).
interface i2s_axis_rx_if #(
    parameter int unsigned DATA_WIDTH = 24
) ();
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/i2s_axis_rx_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module i2s_axis_rx_fifo #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end
endmodule

// File: rtl/i2s_axis_rx.sv
// I2S slave receiver: oversamples sclk/lrck/sdin in the clk domain and emits 24-bit samples on AXI-Stream.
module i2s_axis_rx
    import i2s_axis_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = I2S_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH    = I2S_FIFO_DEPTH,
    parameter int unsigned SYNC_STAGES   = I2S_SYNC_STAGES,
    parameter int unsigned ERR_CNT_WIDTH = I2S_ERR_CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_sclk,
    input  logic                     i_lrck,
    input  logic                     i_sdin,
    input  logic                     i_clr_status,
    output logic                     o_overflow,
    output logic [ERR_CNT_WIDTH-1:0] o_frame_err_cnt,
    i2s_axis_rx_if.master            m_axis
);
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic [SYNC_STAGES-1:0]   r_sclk_sync;
    logic [SYNC_STAGES-1:0]   r_lrck_sync;
    logic [SYNC_STAGES-1:0]   r_sdin_sync;
    logic                     r_sclk_d;
    logic                     r_lrck_prev;
    i2s_state_e               r_state;
    i2s_state_e               w_state_nxt;
    logic [CNT_W-1:0]         r_bit_cnt;
    logic [CNT_W-1:0]         w_bit_cnt_nxt;
    logic                     r_chan;
    logic                     w_chan_nxt;
    logic [DATA_WIDTH-2:0]    r_shreg;
    logic [DATA_WIDTH-2:0]    w_shreg_nxt;
    logic [DATA_WIDTH-1:0]    w_word;
    logic                     w_push;
    logic                     w_frame_err;
    logic                     w_sclk_s;
    logic                     w_lrck_s;
    logic                     w_sdin_s;
    logic                     w_sclk_rise;
    logic                     w_lr_edge;
    logic                     w_pop;
    logic                     w_drop;
    logic                     w_fifo_empty;
    logic                     w_fifo_full;
    logic [DATA_WIDTH:0]      w_fifo_dout;
    logic                     r_overflow;
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

    // All three inputs share the same synchronizer depth so lrck/sdin line up with sclk.
    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_lrck_s    = r_lrck_sync[SYNC_STAGES-1];
    assign w_sdin_s    = r_sdin_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s && !r_sclk_d;
    assign w_lr_edge   = w_sclk_rise && (w_lrck_s != r_lrck_prev);
    assign w_word      = {r_shreg, w_sdin_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_lrck_sync <= '0;
            r_sdin_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_lrck_prev <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_lrck_sync <= {r_lrck_sync[SYNC_STAGES-2:0], i_lrck};
            r_sdin_sync <= {r_sdin_sync[SYNC_STAGES-2:0], i_sdin};
            r_sclk_d    <= w_sclk_s;
            if (w_sclk_rise) begin
                r_lrck_prev <= w_lrck_s;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= SYNC_WAIT;
            r_bit_cnt <= '0;
            r_chan    <= I2S_CH_LEFT;
            r_shreg   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_chan    <= w_chan_nxt;
            r_shreg   <= w_shreg_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_chan_nxt    = r_chan;
        w_shreg_nxt   = r_shreg;
        w_push        = 1'b0;
        w_frame_err   = 1'b0;
        case (r_state)
            SYNC_WAIT: begin
                if (w_lr_edge && (w_lrck_s == I2S_CH_LEFT)) begin
                    w_state_nxt   = SHIFT;
                    w_bit_cnt_nxt = '0;
                    w_chan_nxt    = I2S_CH_LEFT;
                end
            end
            SHIFT: begin
                // A word-select edge before the LSB means the slot was short.
                if (w_lr_edge) begin
                    w_frame_err   = 1'b1;
                    w_bit_cnt_nxt = '0;
                    w_chan_nxt    = w_lrck_s;
                end else if (w_sclk_rise) begin
                    w_shreg_nxt   = w_word[DATA_WIDTH-2:0];
                    w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    if (r_bit_cnt == LAST_BIT) begin
                        w_push      = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (w_lr_edge) begin
                    w_state_nxt   = SHIFT;
                    w_bit_cnt_nxt = '0;
                    w_chan_nxt    = w_lrck_s;
                end
            end
            default: w_state_nxt = SYNC_WAIT;
        endcase
    end

    i2s_axis_rx_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({r_chan, w_word}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    assign m_axis.valid = !w_fifo_empty;
    assign m_axis.data  = w_fifo_dout[DATA_WIDTH-1:0];
    assign m_axis.last  = w_fifo_dout[DATA_WIDTH];
    assign w_pop        = !w_fifo_empty && m_axis.ready;
    assign w_drop       = w_push && w_fifo_full && !w_pop;

    // A new event in the same cycle as a clear wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clr_status) begin
                r_overflow <= 1'b0;
            end
            if (w_frame_err) begin
                if (i_clr_status) begin
                    r_err_cnt <= ERR_CNT_WIDTH'(1);
                end else if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
                end
            end else if (i_clr_status) begin
                r_err_cnt <= '0;
            end
        end
    end

    assign o_overflow      = r_overflow;
    assign o_frame_err_cnt = r_err_cnt;
endmodule

// File: tb/tb_i2s_axis_rx.sv
// Directed bench for i2s_axis_rx: drives I2S frames bit by bit and checks AXIS beats and status.
module tb_i2s_axis_rx;
    localparam int DW = 24;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_sclk;
    logic       i_lrck;
    logic       i_sdin;
    logic       i_clr_status;
    logic       o_overflow;
    logic [7:0] o_frame_err_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    logic [DW:0] beat_q [$];

    i2s_axis_rx_if #(.DATA_WIDTH(DW)) axis_if ();

    always #5 clk = ~clk;

    i2s_axis_rx #(
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (4),
        .SYNC_STAGES   (2),
        .ERR_CNT_WIDTH (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_sclk          (i_sclk),
        .i_lrck          (i_lrck),
        .i_sdin          (i_sdin),
        .i_clr_status    (i_clr_status),
        .o_overflow      (o_overflow),
        .o_frame_err_cnt (o_frame_err_cnt),
        .m_axis          (axis_if)
    );

    // Inputs move 2 ns after posedge, so the negedge sees what the next posedge will sample.
    always @(negedge clk) begin
        if (!rst && axis_if.valid && axis_if.ready) begin
            beat_q.push_back({axis_if.last, axis_if.data});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // strb: 0 none, 1 pulse i_clr_status, 2 pulse ready, aligned to the DUT's sclk_rise cycle.
    task automatic send_bit(input logic lr, input logic d, input int strb);
        tick(); i_sclk = 1'b0; i_lrck = lr; i_sdin = d;
        tick();
        tick(); i_sclk = 1'b1;
        tick();
        tick();
        if (strb == 1) begin
            i_clr_status = 1'b1; tick(); i_clr_status = 1'b0;
        end else if (strb == 2) begin
            axis_if.ready = 1'b1; tick(); axis_if.ready = 1'b0;
        end
    endtask

    task automatic send_slot(input logic lr, input logic [23:0] w, input int len,
                             input int strb_idx, input int strb_kind);
        logic b;
        for (int i = 0; i < len; i++) begin
            b = (i >= 1 && i <= 24) ? w[24-i] : 1'b0;
            send_bit(lr, b, (i == strb_idx) ? strb_kind : 0);
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
        send_slot(1'b0, l, 32, -1, 0);
        send_slot(1'b1, r, 32, -1, 0);
    endtask

    task automatic expect_beat(input string tag, input logic last, input logic [23:0] data);
        logic [DW:0] got;
        int n = 0;
        while (beat_q.size() == 0 && n < 400) begin
            tick();
            n++;
        end
        if (beat_q.size() == 0) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            got = beat_q.pop_front();
            check(tag, {7'd0, got}, {7'd0, last, data});
        end
    endtask

    task automatic expect_none(input string tag);
        repeat (20) tick();
        check(tag, beat_q.size(), 32'd0);
    endtask

    initial begin
        rst = 1'b1; i_sclk = 1'b0; i_lrck = 1'b0; i_sdin = 1'b0;
        i_clr_status = 1'b0; axis_if.ready = 1'b1;
        repeat (5) tick();
        check("rst_valid", {31'd0, axis_if.valid}, 32'd0);
        check("rst_data", {8'd0, axis_if.data}, 32'd0);
        check("rst_last", {31'd0, axis_if.last}, 32'd0);
        check("rst_ovf", {31'd0, o_overflow}, 32'd0);
        check("rst_errcnt", {24'd0, o_frame_err_cnt}, 32'd0);
        rst = 1'b0;
        tick();

        // Start mid right slot: nothing until the first right->left edge.
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b1, 0);
        expect_none("pre_sync_none");
        for (int f = 0; f < 3; f++) send_frame(24'h800001, 24'h7FFFFE);
        for (int f = 0; f < 3; f++) begin
            expect_beat("basic_left", 1'b0, 24'h800001);
            expect_beat("basic_right", 1'b1, 24'h7FFFFE);
        end
        expect_none("basic_none");
        check("basic_errcnt", {24'd0, o_frame_err_cnt}, 32'd0);
        check("basic_ovf", {31'd0, o_overflow}, 32'd0);

        // Backpressure: six samples into a four-entry buffer.
        axis_if.ready = 1'b0;
        send_frame(24'h111111, 24'h222222);
        send_frame(24'hFFFFFF, 24'h000000);
        check("ovf_before", {31'd0, o_overflow}, 32'd0);
        send_slot(1'b0, 24'h333333, 32, -1, 0);
        check("ovf_after5", {31'd0, o_overflow}, 32'd1);
        check("hold_valid", {31'd0, axis_if.valid}, 32'd1);
        check("hold_data", {8'd0, axis_if.data}, 32'h111111);
        check("hold_last", {31'd0, axis_if.last}, 32'd0);
        send_slot(1'b1, 24'h444444, 32, -1, 0);
        axis_if.ready = 1'b1;
        expect_beat("drain0", 1'b0, 24'h111111);
        expect_beat("drain1", 1'b1, 24'h222222);
        expect_beat("drain2", 1'b0, 24'hFFFFFF);
        expect_beat("drain3", 1'b1, 24'h000000);
        expect_none("drain_none");
        check("drain_valid", {31'd0, axis_if.valid}, 32'd0);
        i_clr_status = 1'b1; tick(); i_clr_status = 1'b0; tick();
        check("ovf_cleared", {31'd0, o_overflow}, 32'd0);

        // Full FIFO with a pop in the push cycle: no drop, order kept.
        axis_if.ready = 1'b0;
        send_frame(24'hA00001, 24'hB00001);
        send_frame(24'hA00002, 24'hB00002);
        send_slot(1'b0, 24'hA00003, 32, 24, 2);
        check("pp_ovf", {31'd0, o_overflow}, 32'd0);
        axis_if.ready = 1'b1;
        expect_beat("pp0", 1'b0, 24'hA00001);
        expect_beat("pp1", 1'b1, 24'hB00001);
        expect_beat("pp2", 1'b0, 24'hA00002);
        expect_beat("pp3", 1'b1, 24'hB00002);
        expect_beat("pp4", 1'b0, 24'hA00003);
        send_slot(1'b1, 24'hB00003, 32, -1, 0);
        expect_beat("pp5", 1'b1, 24'hB00003);

        // Truncated left slot: error counted, right still delivered.
        send_slot(1'b0, 24'hC0FFEE, 16, -1, 0);
        send_slot(1'b1, 24'h123456, 32, -1, 0);
        check("trunc_errcnt", {24'd0, o_frame_err_cnt}, 32'd1);
        expect_beat("trunc_right", 1'b1, 24'h123456);
        expect_none("trunc_none");
        send_frame(24'h654321, 24'hABCDEF);
        expect_beat("post_trunc_l", 1'b0, 24'h654321);
        expect_beat("post_trunc_r", 1'b1, 24'hABCDEF);
        check("post_trunc_errcnt", {24'd0, o_frame_err_cnt}, 32'd1);
        i_clr_status = 1'b1; tick(); i_clr_status = 1'b0; tick();
        check("err_cleared", {24'd0, o_frame_err_cnt}, 32'd0);

        // Both slots short, ~259 errors: counter must stop at 255.
        for (int f = 0; f < 130; f++) begin
            send_slot(1'b0, 24'h5A5A5A, 16, -1, 0);
            send_slot(1'b1, 24'hA5A5A5, 16, -1, 0);
        end
        check("sat_errcnt", {24'd0, o_frame_err_cnt}, 32'd255);
        check("sat_no_beats", beat_q.size(), 32'd0);

        // Clear coincident with a frame error: counter reads 1.
        send_slot(1'b0, 24'h0F0F0F, 32, 0, 1);
        send_slot(1'b1, 24'hF0F0F0, 32, -1, 0);
        check("clr_coinc_errcnt", {24'd0, o_frame_err_cnt}, 32'd1);
        expect_beat("clr_coinc_l", 1'b0, 24'h0F0F0F);
        expect_beat("clr_coinc_r", 1'b1, 24'hF0F0F0);

        // Reset mid left slot with samples pending.
        axis_if.ready = 1'b0;
        send_frame(24'h010203, 24'h040506);
        check("prerst_valid", {31'd0, axis_if.valid}, 32'd1);
        send_slot(1'b0, 24'h777777, 11, -1, 0);
        tick(); rst = 1'b1; #1;
        check("midrst_valid", {31'd0, axis_if.valid}, 32'd0);
        check("midrst_data", {8'd0, axis_if.data}, 32'd0);
        check("midrst_errcnt", {24'd0, o_frame_err_cnt}, 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 21; i++) send_bit(1'b0, 1'b1, 0);
        send_slot(1'b1, 24'h999999, 32, -1, 0);
        send_frame(24'h0A0B0C, 24'h0D0E0F);
        axis_if.ready = 1'b1;
        expect_beat("postrst_l", 1'b0, 24'h0A0B0C);
        expect_beat("postrst_r", 1'b1, 24'h0D0E0F);
        expect_none("postrst_none");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
